// File: rtl/multiplexer.sv
// Parameterised 2:1 word multiplexer with a combinational output, plus a
// registered copy of the output, registered select and a saturating select-toggle counter.
module multiplexer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Sw,
  output logic [WIDTH-1:0] out,
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] out_q,
  output logic             sw_q,
  output logic [7:0]       toggle_cnt
);

  localparam int unsigned CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] w_out;
  logic             w_toggle;
  logic             w_cnt_sat;
  logic [WIDTH-1:0] r_out_q;
  logic             r_sw_q;
  logic [CNT_W-1:0] r_toggle_cnt;

  // Plain ?: keeps the bitwise X-merge behaviour when the select is unknown
  assign w_out     = Sw ? b : a;
  assign w_toggle  = (Sw != r_sw_q);
  assign w_cnt_sat = (r_toggle_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_q      <= '0;
      r_sw_q       <= 1'b0;
      r_toggle_cnt <= '0;
    end else begin
      r_out_q <= w_out;
      r_sw_q  <= Sw;
      if (w_toggle && !w_cnt_sat) begin
        r_toggle_cnt <= CNT_W'(r_toggle_cnt + CNT_W'(1));
      end
    end
  end

  assign out        = w_out;
  assign out_q      = r_out_q;
  assign sw_q       = r_sw_q;
  assign toggle_cnt = r_toggle_cnt;

endmodule

// File: tb/tb_multiplexer.sv
// Self-checking bench for multiplexer: combinational path, reset, toggle
// counter saturation and scoreboarded random sweeps at WIDTH=1 and WIDTH=32.
module tb_multiplexer;

  logic clk;
  logic clk_en;
  logic rst_n;

  logic [3:0]  a4, b4, out4, out_q4;
  logic        sw4, sw_q4;
  logic [7:0]  cnt4;

  logic        a1, b1, out1, out_q1, sw1, sw_q1;
  logic [7:0]  cnt1;

  logic [31:0] a32, b32, out32, out_q32;
  logic        sw32, sw_q32;
  logic [7:0]  cnt32;

  int n_tests;
  int n_fail;

  multiplexer #(.WIDTH(4)) u_dut4 (
    .a(a4), .b(b4), .Sw(sw4), .out(out4), .clk(clk), .rst_n(rst_n),
    .out_q(out_q4), .sw_q(sw_q4), .toggle_cnt(cnt4)
  );

  multiplexer #(.WIDTH(1)) u_dut1 (
    .a(a1), .b(b1), .Sw(sw1), .out(out1), .clk(clk), .rst_n(rst_n),
    .out_q(out_q1), .sw_q(sw_q1), .toggle_cnt(cnt1)
  );

  multiplexer #(.WIDTH(32)) u_dut32 (
    .a(a32), .b(b32), .Sw(sw32), .out(out32), .clk(clk), .rst_n(rst_n),
    .out_q(out_q32), .sw_q(sw_q32), .toggle_cnt(cnt32)
  );

  initial clk = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  task automatic test_comb_no_clock();
    sw4 = 1'b0; a4 = 4'b0011; b4 = 4'b1010;
    #1;
    n_tests++;
    if (out4 !== 4'b0011) begin
      n_fail++; $display("FAIL comb_sel_a: got %b expected %b", out4, 4'b0011);
    end
    a4 = 4'b1100; b4 = 4'b0101;
    #1;
    n_tests++;
    if (out4 !== 4'b1100) begin
      n_fail++; $display("FAIL comb_new_a: got %b expected %b", out4, 4'b1100);
    end
    sw4 = 1'b1;
    #1;
    n_tests++;
    if (out4 !== 4'b0101) begin
      n_fail++; $display("FAIL comb_sel_b: got %b expected %b", out4, 4'b0101);
    end
  endtask

  // Only the bits where a and b agree are defined when the select is unknown
  task automatic test_x_select();
    logic [3:0] masked;
    sw4 = 1'bx; a4 = 4'b0110; b4 = 4'b0101;
    #1;
    masked = out4 & 4'b1100;
    n_tests++;
    if (masked !== 4'b0100) begin
      n_fail++; $display("FAIL x_select_agree_bits: got %b expected %b", masked, 4'b0100);
    end
  endtask

  task automatic test_reset();
    sw4 = 1'b0; a4 = 4'b0011; b4 = 4'b1010;
    rst_n = 1'b0;
    clk_en = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (out_q4 !== 4'b0000 || sw_q4 !== 1'b0 || cnt4 !== 8'd0) begin
      n_fail++; $display("FAIL reset_state: got out_q=%b sw_q=%b cnt=%0d expected 0000/0/0",
                         out_q4, sw_q4, cnt4);
    end
    n_tests++;
    if (out4 !== 4'b0011) begin
      n_fail++; $display("FAIL reset_out_tracks_a: got %b expected %b", out4, 4'b0011);
    end
    sw4 = 1'b1;
    #1;
    n_tests++;
    if (out4 !== 4'b1010) begin
      n_fail++; $display("FAIL reset_out_tracks_b: got %b expected %b", out4, 4'b1010);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (out_q4 !== 4'b1010 || sw_q4 !== 1'b1 || cnt4 !== 8'd1) begin
      n_fail++; $display("FAIL first_edge_after_reset: got out_q=%b sw_q=%b cnt=%0d expected 1010/1/1",
                         out_q4, sw_q4, cnt4);
    end
  endtask

  task automatic test_saturation();
    int m_cnt;
    logic m_sw;
    m_cnt = 1; m_sw = 1'b1;
    for (int i = 0; i < 300; i++) begin
      sw4 = ~sw4;
      if (sw4 != m_sw && m_cnt < 255) m_cnt++;
      m_sw = sw4;
      @(posedge clk); #1;
      n_tests++;
      if (cnt4 !== 8'(m_cnt)) begin
        n_fail++; $display("FAIL toggle_count cycle %0d: got %0d expected %0d", i, cnt4, m_cnt);
      end
    end
    n_tests++;
    if (cnt4 !== 8'd255) begin
      n_fail++; $display("FAIL toggle_saturated: got %0d expected 255", cnt4);
    end
    for (int i = 0; i < 4; i++) @(posedge clk);
    #1;
    n_tests++;
    if (cnt4 !== 8'd255) begin
      n_fail++; $display("FAIL toggle_hold_255: got %0d expected 255", cnt4);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (cnt4 !== 8'd0 || sw_q4 !== 1'b0 || out_q4 !== 4'b0000) begin
      n_fail++; $display("FAIL reset_after_saturation: got cnt=%0d sw_q=%b out_q=%b expected 0/0/0000",
                         cnt4, sw_q4, out_q4);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_no_toggle();
    sw4 = 1'b0;
    for (int i = 0; i < 3; i++) @(posedge clk);
    #1;
    n_tests++;
    if (cnt4 !== 8'd0 || sw_q4 !== 1'b0) begin
      n_fail++; $display("FAIL steady_zero_no_count: got cnt=%0d sw_q=%b expected 0/0", cnt4, sw_q4);
    end
    sw4 = 1'b1;
    for (int i = 0; i < 3; i++) @(posedge clk);
    #1;
    n_tests++;
    if (cnt4 !== 8'd1 || sw_q4 !== 1'b1) begin
      n_fail++; $display("FAIL single_rise_counts_once: got cnt=%0d sw_q=%b expected 1/1", cnt4, sw_q4);
    end
  endtask

  task automatic test_sweep();
    logic        q1_out[$];
    logic        q1_sw[$];
    logic [31:0] q32_out[$];
    logic        q32_sw[$];
    logic        e1, es;
    logic [31:0] e32;
    for (int i = 0; i <= 200; i++) begin
      @(posedge clk); #1;
      if (q1_out.size() != 0) begin
        e1 = q1_out.pop_front(); es = q1_sw.pop_front();
        n_tests++;
        if (out_q1 !== e1 || sw_q1 !== es) begin
          n_fail++; $display("FAIL sweep_w1_reg cycle %0d: got out_q=%b sw_q=%b expected %b/%b",
                             i, out_q1, sw_q1, e1, es);
        end
      end
      if (q32_out.size() != 0) begin
        e32 = q32_out.pop_front(); es = q32_sw.pop_front();
        n_tests++;
        if (out_q32 !== e32 || sw_q32 !== es) begin
          n_fail++; $display("FAIL sweep_w32_reg cycle %0d: got out_q=%h sw_q=%b expected %h/%b",
                             i, out_q32, sw_q32, e32, es);
        end
      end
      if (i == 200) break;
      a1 = 1'($urandom); b1 = 1'($urandom); sw1 = 1'($urandom);
      a32 = $urandom; b32 = $urandom; sw32 = 1'($urandom);
      #1;
      e1  = sw1 ? b1 : a1;
      e32 = sw32 ? b32 : a32;
      n_tests++;
      if (out1 !== e1) begin
        n_fail++; $display("FAIL sweep_w1_comb cycle %0d: got %b expected %b", i, out1, e1);
      end
      n_tests++;
      if (out32 !== e32) begin
        n_fail++; $display("FAIL sweep_w32_comb cycle %0d: got %h expected %h", i, out32, e32);
      end
      q1_out.push_back(e1);   q1_sw.push_back(sw1);
      q32_out.push_back(e32); q32_sw.push_back(sw32);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    clk_en = 1'b0; rst_n = 1'b1;
    a4 = '0; b4 = '0; sw4 = 1'b0;
    a1 = 1'b0; b1 = 1'b0; sw1 = 1'b0;
    a32 = '0; b32 = '0; sw32 = 1'b0;
    test_comb_no_clock();
    test_x_select();
    test_reset();
    test_saturation();
    test_no_toggle();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
